br_write_ctrl: RTL and testbench
================================

# br_write_ctrl

Write-port controller and scoreboard for the 32×32 register bank (`Banco_Registros`) of the MIPS core. It arbitrates one write port between the ALU and memory writeback paths, and drives `RegWrite`/`Write_Reg`/`Write_Data` from registers. It also tracks outstanding writes per register and raises `stall` when an instruction's sources or destination are not yet safe.

## Interface

**Parameters**
- `NREG`, 32, number of architectural registers
- `AW`, 5, register index width
- `DW`, 32, data width
- `CW`, 2, pending-write counter width per register (saturation limit 2^CW−1)

**Ports**
- `clk`  in  1  core clock; all state changes on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `alu_valid`  in  1  ALU writeback request
- `alu_reg`  in  AW  ALU destination register
- `alu_data`  in  DW  ALU result
- `alu_ready`  out  1  ALU request granted this cycle
- `mem_valid`  in  1  memory-load writeback request
- `mem_reg`  in  AW  load destination register
- `mem_data`  in  DW  load data
- `mem_ready`  out  1  load request granted this cycle
- `issue_valid`  in  1  instruction issuing with a destination register
- `issue_reg`  in  AW  destination of the issuing instruction
- `src1_reg`, `src2_reg`  in  AW  source registers of the decoding instruction
- `stall`  out  1  decode must hold
- `RegWrite`  out  1  register bank write enable
- `Write_Reg`  out  AW  register bank write index
- `Write_Data`  out  DW  register bank write data
- `busy`  out  NREG  bit i set when register i has a pending count ≠ 0
- `sb_err`  out  1  sticky flag: writeback committed to a register with count 0

## Operation

**Arbitration**
- Round-robin between the ALU and MEM paths. `last_grant` is one flop.
- Only one path valid → that path is granted.
- Both paths valid → the path not in `last_grant` is granted.
- `last_grant` updates only on a grant.
- `*_ready` is combinational from `*_valid` and `last_grant`. A transfer occurs when `valid & ready`. The requester must hold its request until `ready` is seen.

**Write stage**
- A granted transfer registers `{RegWrite, Write_Reg, Write_Data}`.
- A grant to register 0 is accepted (ready asserted) but `RegWrite` stays 0.
- No grant → `RegWrite` = 0 and `Write_Reg`/`Write_Data` hold their previous values.

**Scoreboard**
- One CW-bit counter per register.
- Issue with `issue_reg ≠ 0` → counter increments.
- Commit (grant) to a register → counter decrements.
- Issue and commit to the same register in the same cycle → net unchanged.
- Commit to a register with count 0 → counter stays 0 and `sb_err` is set.
- Register 0 counter is constant 0.
- `stall` = `busy[src1_reg] | busy[src2_reg] | (issue_valid & count[issue_reg] == 2^CW−1)`.
- While `stall` is high, the issue stage does not assert `issue_valid`. An increment at saturation is ignored.

## Timing

- Reset values: all counters 0, `busy` 0, `RegWrite` 0, `Write_Reg` 0, `Write_Data` 0, `sb_err` 0. `last_grant` = MEM, so the ALU wins the first conflict.
- Reset applied mid-operation discards pending counts and any in-flight grant in that cycle.
- Grant in cycle N → `RegWrite` high during cycle N+1 only. The bank updates combinationally in N+1.
- The counter decrements at the edge ending cycle N. A source that was pending only on that write therefore un-stalls in N+1, the same cycle the bank holds the new value.
- `stall` is combinational from registered counters and the current inputs. It has no dependence on same-cycle grants.
- Throughput: one write per cycle. A requester that loses arbitration waits at most one cycle.

## Structure

- Package `br_pkg`:
  - constants `NREG`, `AW`, `DW`, `CW`
  - enum `wb_src_t` {`WB_ALU`, `WB_MEM`} for `last_grant`
- Sub-module `br_scoreboard`: counter array, `busy`, saturation detect, `sb_err`.
- Top level: arbiter and write-stage registers.

## Test plan

- **Reset:** `rst_n`=0 for 2 cycles with all requests high → `RegWrite`=0, `busy`=0, `stall`=0, `sb_err`=0.
- **Single write:** issue r5, then ALU writes r5=0xDEADBEEF → `stall` high with `src1_reg`=5 until the grant. The next cycle has `RegWrite`=1, `Write_Reg`=5, `Write_Data`=0xDEADBEEF, and `stall` drops in that same cycle.
- **Conflict alternation:** issue r3 and r4, then ALU r3 and MEM r4 valid together for 2 cycles → ALU granted first, MEM second, `RegWrite` pulses in consecutive cycles, `busy`=0 at the end.
- **Same-cycle issue and commit:** r7 count 1, then issue r7 in the same cycle as the MEM commit to r7 → count stays 1, `busy[7]`=1.
- **Saturation:** 3 issues to r9 with no writeback → `stall`=1 on a 4th `issue_valid` for r9. Three commits return the count to 0.
- **Error and r0:** commit to r12 with count 0 → `sb_err`=1 and sticky, write still performed. Commit to r0 → `alu_ready`=1 and `RegWrite`=0.

Source files
------------

// File: rtl/br_pkg.sv
// Shared sizes and write-back source encoding for the register-bank write controller.
package br_pkg;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int CW   = 2;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_src_t;
endpackage

// File: rtl/br_write_ctrl_if.sv
// Bundle of write-back requests, issue/decode hazard signals and register-bank drive.
interface br_write_ctrl_if;
   import br_pkg::*;

   logic            alu_valid;
   logic [AW-1:0]   alu_reg;
   logic [DW-1:0]   alu_data;
   logic            alu_ready;
   logic            mem_valid;
   logic [AW-1:0]   mem_reg;
   logic [DW-1:0]   mem_data;
   logic            mem_ready;
   logic            issue_valid;
   logic [AW-1:0]   issue_reg;
   logic [AW-1:0]   src1_reg;
   logic [AW-1:0]   src2_reg;
   logic            stall;
   logic            RegWrite;
   logic [AW-1:0]   Write_Reg;
   logic [DW-1:0]   Write_Data;
   logic [NREG-1:0] busy;
   logic            sb_err;

   modport slave (
      input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
      input  issue_valid, issue_reg, src1_reg, src2_reg,
      output alu_ready, mem_ready, stall, RegWrite, Write_Reg, Write_Data, busy, sb_err
   );

   modport master (
      output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
      output issue_valid, issue_reg, src1_reg, src2_reg,
      input  alu_ready, mem_ready, stall, RegWrite, Write_Reg, Write_Data, busy, sb_err
   );
endinterface

// File: rtl/br_scoreboard.sv
// Per-register pending-write counters; produces busy, decode stall and a sticky underflow flag.
module br_scoreboard
   import br_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_reg,
   input  logic            commit_valid,
   input  logic [AW-1:0]   commit_reg,
   input  logic [AW-1:0]   src1_reg,
   input  logic [AW-1:0]   src2_reg,
   output logic [NREG-1:0] busy,
   output logic            stall,
   output logic            sb_err
);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [NREG-1:0][CW-1:0] count;
   logic                    err_hit;

   // Simultaneous issue and commit cancel; increments stop at saturation, decrements at zero.
   function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                              input logic inc, input logic dec);
      logic [CW-1:0] r;
      r = cnt;
      if (inc && !dec && cnt != CNT_MAX)
         r = cnt + CW'(1);
      else if (dec && !inc && cnt != '0)
         r = cnt - CW'(1);
      return r;
   endfunction

   assign err_hit = commit_valid && (commit_reg != '0) && (count[commit_reg] == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count  <= '0;
         sb_err <= 1'b0;
      end else begin
         count[0] <= '0;
         for (int i = 1; i < NREG; i++) begin
            count[i] <= cnt_next(count[i],
                                 issue_valid  && (issue_reg  == AW'(i)),
                                 commit_valid && (commit_reg == AW'(i)));
         end
         if (err_hit)
            sb_err <= 1'b1;
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NREG; i++)
         busy[i] = |count[i];
   end

   // Stall looks only at registered counts, never at this cycle's commit.
   assign stall = busy[src1_reg] | busy[src2_reg] |
                  (issue_valid & (count[issue_reg] == CNT_MAX));
endmodule

// File: rtl/br_write_ctrl.sv
// Round-robin ALU/MEM write-port arbiter with registered register-bank write stage.
module br_write_ctrl
   import br_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   br_write_ctrl_if.slave  bus
);
   wb_src_t         last_grant;
   logic            alu_grant;
   logic            mem_grant;
   logic            grant;
   logic [AW-1:0]   grant_reg;
   logic [DW-1:0]   grant_data;
   logic            reg_write_p1;
   logic [AW-1:0]   write_reg_p1;
   logic [DW-1:0]   write_data_p1;

   // On conflict the path that did not win last time is granted.
   always_comb begin
      alu_grant  = bus.alu_valid & (~bus.mem_valid | (last_grant == WB_MEM));
      mem_grant  = bus.mem_valid & (~bus.alu_valid | (last_grant == WB_ALU));
      grant      = alu_grant | mem_grant;
      grant_reg  = alu_grant ? bus.alu_reg  : bus.mem_reg;
      grant_data = alu_grant ? bus.alu_data : bus.mem_data;
   end

   assign bus.alu_ready = alu_grant;
   assign bus.mem_ready = mem_grant;

   // p0 -> p1: granted transfer becomes the bank write in the following cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant    <= WB_MEM;
         reg_write_p1  <= 1'b0;
         write_reg_p1  <= '0;
         write_data_p1 <= '0;
      end else if (grant) begin
         last_grant    <= alu_grant ? WB_ALU : WB_MEM;
         reg_write_p1  <= (grant_reg != '0);
         write_reg_p1  <= grant_reg;
         write_data_p1 <= grant_data;
      end else begin
         reg_write_p1  <= 1'b0;
      end
   end

   assign bus.RegWrite   = reg_write_p1;
   assign bus.Write_Reg  = write_reg_p1;
   assign bus.Write_Data = write_data_p1;

   br_scoreboard u_sb (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (bus.issue_valid),
      .issue_reg    (bus.issue_reg),
      .commit_valid (grant),
      .commit_reg   (grant_reg),
      .src1_reg     (bus.src1_reg),
      .src2_reg     (bus.src2_reg),
      .busy         (bus.busy),
      .stall        (bus.stall),
      .sb_err       (bus.sb_err)
   );
endmodule

// File: tb/tb_br_write_ctrl.sv
// Directed bench for br_write_ctrl: expected bank writes are queued and checked by a monitor.
module tb_br_write_ctrl;
   import br_pkg::*;

   logic clk;
   logic rst_n;
   br_write_ctrl_if bus ();

   br_write_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } wr_t;

   wr_t expq[$];
   int  checks = 0;
   int  passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [AW-1:0] r, input logic [DW-1:0] d);
      wr_t e;
      e.r = r;
      e.d = d;
      expq.push_back(e);
   endtask

   // Monitor: every bank write must match the oldest queued expectation.
   always @(negedge clk) begin
      wr_t e;
      if (bus.RegWrite === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_write: got reg %0d data %0h expected no write",
                     bus.Write_Reg, bus.Write_Data);
         end else begin
            e = expq.pop_front();
            chk("write_reg",  32'(bus.Write_Reg), 32'(e.r));
            chk("write_data", bus.Write_Data, e.d);
         end
      end
   end

   initial begin
      rst_n           = 1'b0;
      bus.alu_valid   = 1'b1;
      bus.alu_reg     = 5'd5;
      bus.alu_data    = 32'h1111_1111;
      bus.mem_valid   = 1'b1;
      bus.mem_reg     = 5'd6;
      bus.mem_data    = 32'h2222_2222;
      bus.issue_valid = 1'b1;
      bus.issue_reg   = 5'd5;
      bus.src1_reg    = 5'd0;
      bus.src2_reg    = 5'd0;
      repeat (2) step();

      // Reset state
      rst_n = 1'b1;
      bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.issue_valid = 1'b0;
      #1;
      chk("rst_regwrite",   32'(bus.RegWrite), 0);
      chk("rst_write_reg",  32'(bus.Write_Reg), 0);
      chk("rst_write_data", bus.Write_Data, 0);
      chk("rst_busy",       bus.busy, 0);
      chk("rst_stall",      32'(bus.stall), 0);
      chk("rst_sb_err",     32'(bus.sb_err), 0);

      // Single write to r5
      bus.issue_valid = 1'b1; bus.issue_reg = 5'd5;
      step();
      bus.issue_valid = 1'b0; bus.src1_reg = 5'd5;
      #1;
      chk("r5_stall_a", 32'(bus.stall), 1);
      chk("r5_busy",    bus.busy, 32'h0000_0020);
      step();
      chk("r5_stall_b", 32'(bus.stall), 1);
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
      expect_wr(5'd5, 32'hDEAD_BEEF);
      #1;
      chk("r5_alu_ready",   32'(bus.alu_ready), 1);
      chk("r5_stall_grant", 32'(bus.stall), 1);
      step();
      bus.alu_valid = 1'b0;
      #1;
      chk("r5_stall_drop", 32'(bus.stall), 0);
      chk("r5_regwrite",   32'(bus.RegWrite), 1);
      bus.src1_reg = 5'd0;

      // Reset mid-operation discards the pending count and the in-flight grant
      bus.issue_valid = 1'b1; bus.issue_reg = 5'd20;
      step();
      rst_n = 1'b0;
      bus.issue_reg = 5'd21;
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd20; bus.alu_data = 32'h2020_2020;
      step();
      rst_n = 1'b1;
      bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
      #1;
      chk("midrst_regwrite", 32'(bus.RegWrite), 0);
      chk("midrst_busy",     bus.busy, 0);

      // Conflict: ALU first after reset, MEM next
      bus.issue_valid = 1'b1; bus.issue_reg = 5'd3;
      step();
      bus.issue_reg = 5'd4;
      step();
      bus.issue_valid = 1'b0;
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'h0000_0033;
      bus.mem_valid = 1'b1; bus.mem_reg = 5'd4; bus.mem_data = 32'h0000_0044;
      expect_wr(5'd3, 32'h0000_0033);
      expect_wr(5'd4, 32'h0000_0044);
      #1;
      chk("conf_alu_ready", 32'(bus.alu_ready), 1);
      chk("conf_mem_ready", 32'(bus.mem_ready), 0);
      step();
      bus.alu_valid = 1'b0;
      #1;
      chk("conf_mem_ready2", 32'(bus.mem_ready), 1);
      chk("conf_regwrite1",  32'(bus.RegWrite), 1);
      step();
      bus.mem_valid = 1'b0;
      #1;
      chk("conf_regwrite2", 32'(bus.RegWrite), 1);
      step();
      chk("conf_busy",      bus.busy, 0);
      chk("conf_regwrite3", 32'(bus.RegWrite), 0);

      // Same-cycle issue and commit on r7
      bus.issue_valid = 1'b1; bus.issue_reg = 5'd7;
      step();
      bus.mem_valid = 1'b1; bus.mem_reg = 5'd7; bus.mem_data = 32'h0000_0077;
      expect_wr(5'd7, 32'h0000_0077);
      step();
      bus.issue_valid = 1'b0; bus.mem_valid = 1'b0;
      #1;
      chk("same_busy", bus.busy, 32'h0000_0080);
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd7; bus.alu_data = 32'h0000_0070;
      expect_wr(5'd7, 32'h0000_0070);
      step();
      bus.alu_valid = 1'b0;
      #1;
      chk("same_busy_clear", bus.busy, 0);

      // Saturation on r9
      for (int k = 0; k < 3; k++) begin
         bus.issue_valid = 1'b1; bus.issue_reg = 5'd9;
         #1;
         chk("sat_no_stall", 32'(bus.stall), 0);
         step();
      end
      #1;
      chk("sat_stall", 32'(bus.stall), 1);
      bus.issue_valid = 1'b0;
      #1;
      chk("sat_stall_off", 32'(bus.stall), 0);
      chk("sat_busy",      bus.busy, 32'h0000_0200);
      for (int k = 0; k < 3; k++) begin
         bus.alu_valid = 1'b1; bus.alu_reg = 5'd9; bus.alu_data = 32'h0000_0090 + k;
         expect_wr(5'd9, 32'h0000_0090 + k);
         step();
      end
      bus.alu_valid = 1'b0;
      #1;
      chk("sat_busy_clear", bus.busy, 0);
      chk("sat_no_err",     32'(bus.sb_err), 0);

      // Commit to r12 with count 0
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd12; bus.alu_data = 32'hC0C0_C0C0;
      expect_wr(5'd12, 32'hC0C0_C0C0);
      step();
      bus.alu_valid = 1'b0;
      #1;
      chk("err_set", 32'(bus.sb_err), 1);
      step();
      chk("err_sticky", 32'(bus.sb_err), 1);

      // Commit to r0
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'h0000_0001;
      #1;
      chk("r0_ready", 32'(bus.alu_ready), 1);
      step();
      bus.alu_valid = 1'b0;
      #1;
      chk("r0_regwrite", 32'(bus.RegWrite), 0);
      step();
      step();
      chk("queue_drained", expq.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
